// File: rtl/mips_alu_exec_if.sv
// Handshake and operand/result bundle between the pipeline and the
// execution-stage ALU.
interface mips_alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             div_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_operation, a, b,
        input  result, hi, lo, zero, negative, overflow,
        input  div_zero, busy, done
    );

    modport slave (
        input  start, alu_operation, a, b,
        output result, hi, lo, zero, negative, overflow,
        output div_zero, busy, done
    );
endinterface

// File: rtl/mips_alu_exec.sv
// Execution-stage ALU with iterative signed MULT/DIV and HI/LO registers.
// Define ALU_DIV_EN to include the divider; otherwise DIV decodes as NOP.
module mips_alu_exec #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    mips_alu_exec_if.slave bus
);
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_ADDU = 4'd9;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_SUBU = 4'd11;
    localparam logic [3:0] OP_MULT = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t state, state_next;
    logic accept, step, finish;
    logic op_div, iter_op;

    logic [CW-1:0]    cnt;
    logic             sign_a, sign_b, is_div, dz;
    logic [WIDTH-1:0] mag_a, mag_b, mag_d, p_hi, p_lo;

    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf, alu_flags;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign op_div   = DIV_EN && (bus.alu_operation == OP_DIV);
    assign iter_op  = (bus.alu_operation == OP_MULT) || op_div;
    assign mag_a    = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign mag_b    = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign bus.busy = (state != IDLE);

    always_comb begin
        sum       = bus.a + bus.b;
        diff      = bus.a - bus.b;
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_flags = 1'b1;
        case (bus.alu_operation)
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SLL:  alu_res = bus.b << bus.a[CW-1:0];
            OP_SRL:  alu_res = bus.b >> bus.a[CW-1:0];
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.a) < $signed(bus.b))};
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUBU: alu_res = diff;
            default: alu_flags = 1'b0;
        endcase
    end

    // Shared shift register: {acc, multiplier} for MULT, {rem, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, p_hi} +
                    (p_lo[0] ? {1'b0, mag_d} : {(WIDTH+1){1'b0}});
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_d};
        prod_fix  = (sign_a ^ sign_b) ? -{p_hi, p_lo} : {p_hi, p_lo};
        fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = prod_fix[WIDTH-1:0];
        if (is_div) begin
            fix_hi = sign_a ? -p_hi : p_hi;
            fix_lo = dz ? '1 : ((sign_a ^ sign_b) ? -p_lo : p_lo);
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.start;
                if (bus.start && iter_op) state_next = ITER;
            end
            ITER: begin
                step = 1'b1;
                if (cnt == LAST) state_next = FIX;
            end
            FIX: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.result   <= '0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
            bus.overflow <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.done     <= 1'b0;
            cnt          <= '0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            is_div       <= 1'b0;
            dz           <= 1'b0;
            mag_d        <= '0;
            p_hi         <= '0;
            p_lo         <= '0;
        end else begin
            bus.done <= 1'b0;
            if (accept && !iter_op) begin
                bus.result   <= alu_res;
                bus.zero     <= alu_flags && (alu_res == '0);
                bus.negative <= alu_res[WIDTH-1];
                bus.overflow <= alu_ovf;
                bus.done     <= 1'b1;
            end
            if (accept && iter_op) begin
                sign_a <= bus.a[WIDTH-1];
                sign_b <= bus.b[WIDTH-1];
                is_div <= op_div;
                dz     <= (bus.b == '0);
                mag_d  <= op_div ? mag_b : mag_a;
                p_lo   <= op_div ? mag_a : mag_b;
                p_hi   <= '0;
                cnt    <= '0;
            end
            if (step) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    if (!div_diff[WIDTH]) begin
                        p_hi <= div_diff[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        p_hi <= div_shift[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
                end
            end
            if (finish) begin
                bus.hi       <= fix_hi;
                bus.lo       <= fix_lo;
                bus.result   <= fix_lo;
                bus.zero     <= (fix_lo == '0);
                bus.negative <= fix_lo[WIDTH-1];
                bus.overflow <= 1'b0;
                if (is_div) bus.div_zero <= dz;
                bus.done     <= 1'b1;
            end
        end
    end
endmodule

// File: doc/mips_alu_exec.md
# mips_alu_exec

Execution-stage ALU that consumes the 4-bit `alu_operation` code produced by the ALU controller and performs the encoded operation on two 32-bit operands. Single-cycle logic/arithmetic ops and iterative 32-step signed MULT/DIV share one start/busy/done handshake toward the pipeline stall logic. MULT/DIV results land in architectural HI/LO registers held inside this block.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; MULT/DIV iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  request; sampled only while `busy`=0
- `alu_operation`  in  4  0 NOP, 1 XOR, 2 OR, 3 AND, 4 NOR, 5 SLL, 6 SRL, 7 SLT, 8 ADD, 9 ADDU, 10 SUB, 11 SUBU, 12 MULT, 13 DIV; 14/15 = NOP
- `a`  in  WIDTH  operand A (rs, or zero-extended shamt for shifts)
- `b`  in  WIDTH  operand B (rt or immediate)
- `result`  out  WIDTH  registered result
- `hi`, `lo`  out  WIDTH  HI/LO registers
- `zero`, `negative`, `overflow`  out  1  flags of the last completed op
- `div_zero`  out  1  last DIV had `b`=0
- `busy`  out  1  iterative op in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ITER, FIX.
- IDLE + `start` + single-cycle code: compute, register `result`/flags, pulse `done` next cycle; stay IDLE.
- IDLE + `start` + MULT/DIV: latch sign of each operand, magnitudes of `a`/`b`, clear counter; go ITER.
- ITER: one shift-add (MULT) or restoring shift-subtract (DIV) step per cycle; after `WIDTH` steps go FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, return IDLE.
- SLL: `result` = `b` << `a[4:0]`; SRL: logical `b` >> `a[4:0]`.
- SLT: signed compare, `result` = 1 or 0.
- ADD/SUB: `overflow` = signed overflow; ADDU/SUBU/others: `overflow`=0. No result suppression on overflow.
- `zero` = (`result`==0); `negative` = `result[WIDTH-1]`; used by BEQ/BNE/BLEZ/BGTZ/BGEZ via SUB.
- MULT: {hi,lo} = signed 64-bit product; `result` = lo.
- DIV: lo = quotient truncated toward zero, hi = remainder with dividend's sign; `result` = lo.
- DIV by zero: lo = all ones, hi = `a`, `div_zero`=1. DIV 0x80000000 / -1: lo = 0x80000000, hi = 0.
- NOP / codes 14,15: `result`=0, flags cleared, `done` still pulses.
- HI/LO change only on MULT/DIV completion.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0; asserting `rst` mid-ITER aborts the op and leaves HI/LO = 0.
- Single-cycle op: `start` at edge T -> `result`/`done` valid after edge T+1; `busy` stays 0.
- MULT/DIV: `start` at edge T -> `busy`=1 after T+1 through T+`WIDTH`+1; `done`=1 and `busy`=0 after T+`WIDTH`+2 (34 cycles for WIDTH=32).
- `start` while `busy`=1 is ignored; inputs need only be stable at the accepting edge.
- `start` in the `done` cycle is accepted (back-to-back, no bubble).
- `done` never exceeds one cycle; `result` holds until next completion.

## Configuration
- `ALU_DIV_EN` defined: divider datapath present, DIV as above.
- Undefined: no divider logic; code 13 treated as NOP (1-cycle, `result`=0, HI/LO unchanged, `div_zero`=0).

## Test plan
- Reset mid-MULT (cycle 10 of ITER) -> all outputs 0, next ADD 2+3 gives `result`=5, `done` after one cycle.
- ADD 0x7FFFFFFF+1 -> `result`=0x80000000, `overflow`=1, `negative`=1; ADDU same -> `overflow`=0.
- SUB 5-5 -> `zero`=1; SLT -1,1 -> 1; SLL b=1,a=31 -> 0x80000000; SRL b=0x80000000,a=31 -> 1.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, `done` exactly 34 cycles after start; `start` during busy ignored.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 9/0 -> lo=0xFFFFFFFF, hi=9, `div_zero`=1; without `ALU_DIV_EN`, DIV -> 1-cycle `done`, HI/LO unchanged.
- MULT then `start` ADD in `done` cycle -> ADD `done` one cycle later, HI/LO retain MULT result.
